// File: rtl/exec_pkg.sv
// Shared definitions for the exec_stage slice: phase encoding, opcode map,
// register-file write limit and flag-update classification helpers.
package exec_pkg;

    typedef enum logic [1:0] {
        ST_IF  = 2'd0,
        ST_FD  = 2'd1,
        ST_EX  = 2'd2,
        ST_RWB = 2'd3
    } state_t;

    localparam logic [3:0] OPC_MOV  = 4'h0;
    localparam logic [3:0] OPC_ADD  = 4'h1;
    localparam logic [3:0] OPC_LDI  = 4'h2;
    localparam logic [3:0] OPC_SUB  = 4'h3;
    localparam logic [3:0] OPC_INC  = 4'h4;
    localparam logic [3:0] OPC_AND  = 4'h5;
    localparam logic [3:0] OPC_OR   = 4'h6;
    localparam logic [3:0] OPC_XOR  = 4'h7;
    localparam logic [3:0] OPC_SHL  = 4'h8;
    localparam logic [3:0] OPC_SHR  = 4'h9;
    localparam logic [3:0] OPC_NOT  = 4'hA;
    localparam logic [3:0] OPC_ADDC = 4'hB;
    localparam logic [3:0] OPC_DEC  = 4'hC;
    localparam logic [3:0] OPC_BEQ  = 4'hD;
    localparam logic [3:0] OPC_JMP  = 4'hE;
    localparam logic [3:0] OPC_HALT = 4'hF;

    localparam logic [3:0] RF_WRITE_MAX = 4'hC;

    // Opcodes whose carry and overflow come from the adder.
    function automatic logic is_arith(input logic [3:0] op);
        return (op == OPC_ADD) || (op == OPC_ADDC) || (op == OPC_INC) ||
               (op == OPC_SUB) || (op == OPC_DEC);
    endfunction

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OPC_SHL) || (op == OPC_SHR);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational 8-bit ALU for exec_stage; zero latency, no state.
// All add/sub/inc/dec/addc share one adder: a + rhs + cin_eff.
module exec_alu
    import exec_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic [3:0] rb_f,
    output logic [7:0] result,
    output logic       carry,
    output logic       ovf
);

    logic [7:0] w_rhs;
    logic       w_cin_eff;
    logic [8:0] w_sum;

    always_comb begin
        w_rhs     = b;
        w_cin_eff = 1'b0;
        case (opcode)
            OPC_SUB:  begin w_rhs = ~b;     w_cin_eff = 1'b1; end
            OPC_INC:  begin w_rhs = 8'h01;  w_cin_eff = 1'b0; end
            OPC_DEC:  begin w_rhs = 8'hFE;  w_cin_eff = 1'b1; end
            OPC_ADDC: begin w_rhs = b;      w_cin_eff = cin;  end
            default:  begin w_rhs = b;      w_cin_eff = 1'b0; end
        endcase
    end

    assign w_sum = {1'b0, a} + {1'b0, w_rhs} + {8'h00, w_cin_eff};

    always_comb begin
        result = 8'h00;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (opcode)
            OPC_MOV: result = a;
            OPC_LDI: result = {4'h0, rb_f};
            OPC_AND: result = a & b;
            OPC_OR:  result = a | b;
            OPC_XOR: result = a ^ b;
            OPC_NOT: result = ~a;
            OPC_SHL: begin result = {a[6:0], 1'b0}; carry = a[7]; end
            OPC_SHR: begin result = {1'b0, a[7:1]}; carry = a[0]; end
            OPC_ADD, OPC_ADDC, OPC_INC, OPC_SUB, OPC_DEC: begin
                result = w_sum[7:0];
                carry  = w_sum[8];
                // Overflow: both addends share a sign that the sum lost.
                ovf    = (a[7] == w_rhs[7]) && (w_sum[7] != a[7]);
            end
            default: result = 8'h00;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Four-phase (IF/FD/EX/RWB) execute stage; 4 clocks per instruction, HALT parks in EX.
// Optional macro EXEC_STEP_EN adds a step input gating every non-reset update.
module exec_stage
    import exec_pkg::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
`ifdef EXEC_STEP_EN
    input  logic       step,
`endif
    input  logic [3:0] opcode,
    input  logic [3:0] ra_f,
    input  logic [3:0] rb_f,
    input  logic [3:0] rd_f,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic [1:0] state,
    output logic [7:0] pc,
    output logic [7:0] alu_out,
    output logic [7:0] w_reg,
    output logic       rf_we,
    output logic       cout,
    output logic       of,
    output logic       halted
);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_halted;
    logic       w_halted_nxt;
    logic [7:0] r_pc;
    logic [7:0] r_w_reg;
    logic       r_cout;
    logic       r_of;
    logic       r_beq_eq;
    logic       w_adv;
    logic [7:0] w_alu_res;
    logic       w_alu_carry;
    logic       w_alu_ovf;
    logic [7:0] w_pc_nxt;
    logic       w_ex_edge;

`ifdef EXEC_STEP_EN
    assign w_adv = step;
`else
    assign w_adv = 1'b1;
`endif

    exec_alu u_alu (
        .opcode (opcode),
        .a      (op_a),
        .b      (op_b),
        .cin    (r_cout),
        .rb_f   (rb_f),
        .result (w_alu_res),
        .carry  (w_alu_carry),
        .ovf    (w_alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IF;
            r_halted <= 1'b0;
        end else if (w_adv) begin
            r_state  <= w_state_nxt;
            r_halted <= w_halted_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_halted_nxt = r_halted;
        case (r_state)
            ST_IF:  w_state_nxt = ST_FD;
            ST_FD:  w_state_nxt = ST_EX;
            ST_EX: begin
                if (r_halted) begin
                    w_state_nxt = ST_EX;
                end else if (opcode == OPC_HALT) begin
                    w_halted_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_RWB;
                end
            end
            ST_RWB: w_state_nxt = ST_IF;
            default: w_state_nxt = ST_IF;
        endcase
    end

    // Leaving EX toward RWB: the one edge where results and flags commit.
    assign w_ex_edge = (r_state == ST_EX) && !r_halted && (opcode != OPC_HALT);

    always_comb begin
        w_pc_nxt = r_pc + 8'd1;
        if (opcode == OPC_BEQ && r_beq_eq) begin
            w_pc_nxt = r_pc + 8'd1 + {{4{rd_f[3]}}, rd_f};
        end else if (opcode == OPC_JMP) begin
            w_pc_nxt = {ra_f, rb_f};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc     <= PC_RESET;
            r_w_reg  <= 8'h00;
            r_cout   <= 1'b0;
            r_of     <= 1'b0;
            r_beq_eq <= 1'b0;
        end else if (w_adv) begin
            if (w_ex_edge) begin
                r_beq_eq <= (op_a == op_b);
                if (opcode <= RF_WRITE_MAX) begin
                    r_w_reg <= w_alu_res;
                end
                if (is_arith(opcode)) begin
                    r_cout <= w_alu_carry;
                    r_of   <= w_alu_ovf;
                end else if (is_shift(opcode)) begin
                    r_cout <= w_alu_carry;
                    r_of   <= 1'b0;
                end
            end
            if (r_state == ST_RWB) begin
                r_pc <= w_pc_nxt;
            end
        end
    end

    assign state   = r_state;
    assign pc      = r_pc;
    assign w_reg   = r_w_reg;
    assign cout    = r_cout;
    assign of      = r_of;
    assign halted  = r_halted;
    assign alu_out = (r_state == ST_EX && !r_halted) ? w_alu_res : 8'h00;
    assign rf_we   = (r_state == ST_RWB) && (opcode <= RF_WRITE_MAX);

endmodule
